// File: rtl/conv_frame_ctrl.sv
// Frame sequencer feeding a stall-free 3x3 convolution datapath: streams one frame, drains the
// pipeline, tags interior-window results. Optional frame counter via CONV_CTRL_STATS_EN.
module conv_frame_ctrl #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned ROW_SIZE  = 10,
  parameter int unsigned NUM_ROWS  = 10,
  parameter int unsigned PIPE_LAT  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [WORD_SIZE-1:0] i_in_pixel,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  output logic [WORD_SIZE-1:0] o_conv_pixel_in,
  input  logic [WORD_SIZE-1:0] i_conv_pixel_out,
  output logic [WORD_SIZE-1:0] o_out_pixel,
  output logic                 o_out_valid,
  output logic                 o_out_last,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [15:0]          o_frame_cnt
);

  localparam int unsigned COL_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int unsigned ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int unsigned DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic [DRN_W-1:0]    r_drain;
  logic [PIPE_LAT-1:0] r_tag_pipe;
  logic [PIPE_LAT-1:0] r_last_pipe;
  logic                r_err;

  logic w_accept;
  logic w_underrun;
  logic w_start_ok;
  logic w_col_wrap;
  logic w_pix_tag;
  logic w_pix_last;
  logic w_drain_end;

  assign w_col_wrap  = (r_col == COL_W'(ROW_SIZE - 1));
  assign w_pix_last  = w_col_wrap && (r_row == ROW_W'(NUM_ROWS - 1));
  assign w_pix_tag   = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
  assign w_drain_end = (r_drain == DRN_W'(PIPE_LAT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and state-decoded controls
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_underrun  = 1'b0;
    w_start_ok  = 1'b0;
    o_in_ready  = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_accept = 1'b1;
          if (w_pix_last) begin
            w_state_nxt = S_FLUSH;
          end
        end else begin
          w_underrun  = 1'b1;
          w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (w_drain_end) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The datapath never stalls, so any non-accept cycle must present a zero pixel.
  assign o_conv_pixel_in = w_accept ? i_in_pixel : '0;
  assign o_out_pixel     = i_conv_pixel_out;

  // Raster position, drain counter and sticky underrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_drain <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_col <= '0;
        r_row <= '0;
        r_err <= 1'b0;
      end else if (w_accept && !w_pix_last) begin
        if (w_col_wrap) begin
          r_col <= '0;
          r_row <= r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
      if (w_underrun) begin
        r_err <= 1'b1;
      end
      if (r_state == S_FLUSH) begin
        r_drain <= r_drain + DRN_W'(1);
      end else begin
        r_drain <= '0;
      end
    end
  end

  // Tag pipeline aligned with the datapath latency; an underrun voids the whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_pipe  <= '0;
      r_last_pipe <= '0;
    end else if (w_underrun) begin
      r_tag_pipe  <= '0;
      r_last_pipe <= '0;
    end else begin
      r_tag_pipe[0]  <= w_accept && w_pix_tag;
      r_last_pipe[0] <= w_accept && w_pix_last;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        r_tag_pipe[i]  <= r_tag_pipe[i-1];
        r_last_pipe[i] <= r_last_pipe[i-1];
      end
    end
  end

  assign o_out_valid = r_tag_pipe[PIPE_LAT-1];
  assign o_out_last  = r_last_pipe[PIPE_LAT-1];
  assign o_err       = r_err;

`ifdef CONV_CTRL_STATS_EN
  logic [CNT_W-1:0] r_frame_cnt;

  // Counts frames that finished without an underrun
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if ((r_state == S_DONE) && !r_err) begin
      r_frame_cnt <= r_frame_cnt + CNT_W'(1);
    end
  end

  assign o_frame_cnt = r_frame_cnt;
`else
  assign o_frame_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed self-checking bench for conv_frame_ctrl; the convolution datapath is modelled as a
// PIPE_LAT-deep delay line so each result carries the newest pixel of its window.
module tb_conv_frame_ctrl;

  localparam int unsigned WS = 8;
  localparam int unsigned RS = 10;
  localparam int unsigned NR = 10;
  localparam int unsigned PL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start;
  logic [WS-1:0] i_in_pixel;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [WS-1:0] o_conv_pixel_in;
  logic [WS-1:0] i_conv_pixel_out;
  logic [WS-1:0] o_out_pixel;
  logic          o_out_valid;
  logic          o_out_last;
  logic          o_busy;
  logic          o_done;
  logic          o_err;
  logic [15:0]   o_frame_cnt;

  logic [WS-1:0] dp_q [PL];

  int errors = 0;
  int checks = 0;
  int exp_frames = 0;

  conv_frame_ctrl #(
    .WORD_SIZE(WS), .ROW_SIZE(RS), .NUM_ROWS(NR), .PIPE_LAT(PL)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (i_start),
    .i_in_pixel      (i_in_pixel),
    .i_in_valid      (i_in_valid),
    .o_in_ready      (o_in_ready),
    .o_conv_pixel_in (o_conv_pixel_in),
    .i_conv_pixel_out(i_conv_pixel_out),
    .o_out_pixel     (o_out_pixel),
    .o_out_valid     (o_out_valid),
    .o_out_last      (o_out_last),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_err           (o_err),
    .o_frame_cnt     (o_frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dp_q[0] <= o_conv_pixel_in;
    for (int i = 1; i < PL; i++) dp_q[i] <= dp_q[i-1];
  end
  assign i_conv_pixel_out = dp_q[PL-1];

  function automatic logic interior(input int k);
    return (k >= 0) && (k < RS * NR) && (k / RS >= 2) && (k % RS >= 2);
  endfunction

  // One cycle: drive inputs just after the edge, sample outputs 1 ns later.
  task automatic step(input logic s, input logic v, input logic [WS-1:0] p);
    @(posedge clk);
    #1;
    i_start = s; i_in_valid = v; i_in_pixel = p;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; i_start = 1'b0; i_in_valid = 1'b0; i_in_pixel = '0;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (o_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", o_in_ready); end
    checks++; if (o_conv_pixel_in !== 8'h00) begin errors++; $display("FAIL reset_conv_in: got %h want 00", o_conv_pixel_in); end
    checks++; if ({o_out_valid, o_out_last} !== 2'b00) begin errors++; $display("FAIL reset_out_flags: got %b want 00", {o_out_valid, o_out_last}); end
    checks++; if ({o_busy, o_done, o_err} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b want 000", {o_busy, o_done, o_err}); end
    checks++; if (o_frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d want 0", o_frame_cnt); end
    @(posedge clk); #1 rst_n = 1'b1;
    step(1'b0, 1'b0, '0);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", o_busy); end
  endtask

  // Ramp frame started at cycle 0, pixels at cycles 1..100.
  task automatic test_clean_frame(input string nm);
    int first = -1, beats = 0, last_c = -1, done_c = -1, done_n = 0;
    int in_bad = 0, v_bad = 0, p_bad = 0;
    logic v, ev, el, busy106, err1;
    busy106 = 1'bx; err1 = 1'bx;
    for (int t = 0; t <= 108; t++) begin
      v = (t >= 1 && t <= 100);
      step(t == 0, v, WS'(t - 1));
      if (v) begin
        if (o_in_ready !== 1'b1 || o_conv_pixel_in !== WS'(t - 1)) in_bad++;
      end else if (o_in_ready !== 1'b0 || o_conv_pixel_in !== 8'h00) in_bad++;
      ev = interior(t - 5);
      el = (t == 104);
      if (o_out_valid !== ev || o_out_last !== el) v_bad++;
      if (o_out_valid === 1'b1) begin
        beats++;
        if (first < 0) first = t;
        if (o_out_pixel !== WS'(t - 5)) p_bad++;
      end
      if (o_out_last === 1'b1) last_c = t;
      if (o_done === 1'b1) begin done_n++; done_c = t; end
      if (t == 1) err1 = o_err;
      if (t == 106) busy106 = o_busy;
    end
`ifdef CONV_CTRL_STATS_EN
    exp_frames++;
`endif
    checks++; if (in_bad != 0) begin errors++; $display("FAIL %s_input_fwd: %0d bad cycles want 0", nm, in_bad); end
    checks++; if (v_bad != 0) begin errors++; $display("FAIL %s_tag_pattern: %0d bad cycles want 0", nm, v_bad); end
    checks++; if (first != 27) begin errors++; $display("FAIL %s_first_valid: got cycle %0d want 27", nm, first); end
    checks++; if (beats != 64) begin errors++; $display("FAIL %s_beats: got %0d want 64", nm, beats); end
    checks++; if (p_bad != 0) begin errors++; $display("FAIL %s_out_pixel: %0d bad beats want 0", nm, p_bad); end
    checks++; if (last_c != 104) begin errors++; $display("FAIL %s_out_last: got cycle %0d want 104", nm, last_c); end
    checks++; if (done_c != 105 || done_n != 1) begin errors++; $display("FAIL %s_done: got cycle %0d count %0d want 105 x1", nm, done_c, done_n); end
    checks++; if (busy106 !== 1'b0) begin errors++; $display("FAIL %s_idle_106: busy %b want 0", nm, busy106); end
    checks++; if (o_err !== 1'b0 || err1 !== 1'b0) begin errors++; $display("FAIL %s_err: got %b/%b want 0/0", nm, err1, o_err); end
    checks++; if (o_frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL %s_frame_cnt: got %0d want %0d", nm, o_frame_cnt, exp_frames); end
  endtask

  // in_valid drops on the 50th STREAM cycle; valid kept high afterwards must be ignored.
  task automatic test_underrun;
    int in_bad = 0, v_bad = 0, e_bad = 0, done_c = -1, done_n = 0;
    logic v, exp_rdy, busy56;
    logic [WS-1:0] exp_px;
    busy56 = 1'bx;
    for (int t = 0; t <= 60; t++) begin
      v = (t >= 1 && t != 50);
      step(t == 0, v, (t == 50) ? 8'hAA : WS'(t - 1));
      exp_rdy = (t >= 1 && t <= 50);
      exp_px  = (t >= 1 && t <= 49) ? WS'(t - 1) : 8'h00;
      if (o_in_ready !== exp_rdy || o_conv_pixel_in !== exp_px) in_bad++;
      if (o_out_valid !== (t <= 50 && interior(t - 5)) || o_out_last !== 1'b0) v_bad++;
      if (t >= 1 && o_err !== (t >= 51)) e_bad++;
      if (o_done === 1'b1) begin done_n++; done_c = t; end
      if (t == 56) busy56 = o_busy;
    end
    checks++; if (in_bad != 0) begin errors++; $display("FAIL underrun_input: %0d bad cycles want 0", in_bad); end
    checks++; if (v_bad != 0) begin errors++; $display("FAIL underrun_tags: %0d bad cycles want 0", v_bad); end
    checks++; if (e_bad != 0) begin errors++; $display("FAIL underrun_err: %0d bad cycles want 0", e_bad); end
    checks++; if (done_c != 55 || done_n != 1) begin errors++; $display("FAIL underrun_done: got cycle %0d count %0d want 55 x1", done_c, done_n); end
    checks++; if (busy56 !== 1'b0) begin errors++; $display("FAIL underrun_idle: busy %b want 0", busy56); end
    checks++; if (o_frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL underrun_frame_cnt: got %0d want %0d", o_frame_cnt, exp_frames); end
  endtask

  // start and in_valid held high: frame 2 streams from cycle 107.
  task automatic test_back_to_back;
    int in_bad = 0, v_bad = 0, p_bad = 0, beats = 0, d_bad = 0, done_n = 0;
    logic exp_rdy, ev, el, err1, b106, b107, b213;
    err1 = 1'bx; b106 = 1'bx; b107 = 1'bx; b213 = 1'bx;
    for (int t = 0; t <= 214; t++) begin
      step(t <= 110, 1'b1, WS'(t));
      exp_rdy = (t >= 1 && t <= 100) || (t >= 107 && t <= 206);
      if (o_in_ready !== exp_rdy || o_conv_pixel_in !== (exp_rdy ? WS'(t) : 8'h00)) in_bad++;
      ev = interior(t - 5) || interior(t - 111);
      el = (t == 104) || (t == 210);
      if (o_out_valid !== ev || o_out_last !== el) v_bad++;
      if (o_out_valid === 1'b1) begin
        beats++;
        if (o_out_pixel !== WS'(t - 4)) p_bad++;
      end
      if (o_done === 1'b1) done_n++;
      if (o_done !== (t == 105 || t == 211)) d_bad++;
      if (t == 1) err1 = o_err;
      if (t == 106) b106 = o_busy;
      if (t == 107) b107 = o_busy;
      if (t == 213) b213 = o_busy;
    end
`ifdef CONV_CTRL_STATS_EN
    exp_frames += 2;
`endif
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL b2b_err_cleared: got %b want 0", err1); end
    checks++; if (in_bad != 0) begin errors++; $display("FAIL b2b_input: %0d bad cycles want 0", in_bad); end
    checks++; if (v_bad != 0) begin errors++; $display("FAIL b2b_tags: %0d bad cycles want 0", v_bad); end
    checks++; if (beats != 128 || p_bad != 0) begin errors++; $display("FAIL b2b_beats: got %0d beats %0d bad pixels want 128/0", beats, p_bad); end
    checks++; if (d_bad != 0 || done_n != 2) begin errors++; $display("FAIL b2b_done: %0d bad cycles count %0d want 0/2", d_bad, done_n); end
    checks++; if ({b106, b107, b213} !== 3'b010) begin errors++; $display("FAIL b2b_busy: got %b want 010", {b106, b107, b213}); end
    checks++; if (o_frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL b2b_frame_cnt: got %0d want %0d", o_frame_cnt, exp_frames); end
  endtask

  // Reset asserted at FLUSH cycle 102 while a tagged result is on the output.
  task automatic test_reset_flush;
    int done_n = 0, busy_n = 0;
    for (int t = 0; t <= 102; t++) begin
      step(t == 0, t >= 1 && t <= 100, WS'(t - 1));
    end
    checks++; if ({o_busy, o_out_valid} !== 2'b11) begin errors++; $display("FAIL rstflush_pre: busy/valid %b want 11", {o_busy, o_out_valid}); end
    rst_n = 1'b0;
    #1;
    exp_frames = 0;
    checks++; if ({o_in_ready, o_out_valid, o_out_last, o_busy, o_done, o_err} !== 6'b0) begin
      errors++; $display("FAIL rstflush_flags: got %b want 000000", {o_in_ready, o_out_valid, o_out_last, o_busy, o_done, o_err});
    end
    checks++; if (o_conv_pixel_in !== 8'h00 || o_frame_cnt !== 16'd0) begin
      errors++; $display("FAIL rstflush_values: conv_in %h frame_cnt %0d want 00/0", o_conv_pixel_in, o_frame_cnt);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int t = 0; t < 12; t++) begin
      step(1'b0, 1'b0, '0);
      if (o_done === 1'b1) done_n++;
      if (o_busy !== 1'b0) busy_n++;
    end
    checks++; if (done_n != 0 || busy_n != 0) begin errors++; $display("FAIL rstflush_no_done: done %0d busy %0d want 0/0", done_n, busy_n); end
    test_clean_frame("after_rst");
  endtask

  // start pulses while busy or in DONE, and in_valid toggling in IDLE, have no effect.
  task automatic test_ignored;
    int idle_bad = 0, beats = 0, done_c = -1, done_n = 0, late_busy = 0;
    for (int t = 0; t < 8; t++) begin
      step(1'b0, t[0], 8'h5A);
      if ({o_in_ready, o_busy, o_out_valid} !== 3'b000 || o_conv_pixel_in !== 8'h00) idle_bad++;
    end
    checks++; if (idle_bad != 0) begin errors++; $display("FAIL ignored_idle_valid: %0d bad cycles want 0", idle_bad); end
    for (int t = 0; t <= 112; t++) begin
      step(t == 0 || t == 30 || t == 60 || t == 105, t >= 1 && t <= 100, WS'(t - 1));
      if (o_out_valid === 1'b1) beats++;
      if (o_done === 1'b1) begin done_n++; done_c = t; end
      if (t >= 106 && o_busy !== 1'b0) late_busy++;
    end
`ifdef CONV_CTRL_STATS_EN
    exp_frames++;
`endif
    checks++; if (beats != 64) begin errors++; $display("FAIL ignored_beats: got %0d want 64", beats); end
    checks++; if (done_c != 105 || done_n != 1) begin errors++; $display("FAIL ignored_done: got cycle %0d count %0d want 105 x1", done_c, done_n); end
    checks++; if (late_busy != 0) begin errors++; $display("FAIL ignored_start_in_done: %0d busy cycles want 0", late_busy); end
    checks++; if (o_frame_cnt !== 16'(exp_frames)) begin errors++; $display("FAIL ignored_frame_cnt: got %0d want %0d", o_frame_cnt, exp_frames); end
  endtask

  initial begin
    test_reset();
    test_clean_frame("clean");
    test_underrun();
    test_back_to_back();
    test_reset_flush();
    test_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_frame_ctrl.md
# conv_frame_ctrl

Frame sequencer for the 3x3 convolution datapath. The datapath shifts one pixel per clock with no stall or enable, so this block accepts a raster-order frame from an upstream valid/ready source and forwards it as one unbroken pixel per cycle. It then drains the pipeline with zero pixels, tags which datapath outputs correspond to fully interior windows, and reports frame completion and underrun errors. It sits between the pixel source (DMA/FIFO) and the convolution instance and drives the convolution's pixel input.

## Interface
- WORD_SIZE, 8, pixel width
- ROW_SIZE, 10, pixels per row (>= 3)
- NUM_ROWS, 10, rows per frame (>= 3)
- PIPE_LAT, 4, cycles from a window's newest pixel on conv_pixel_in to its result on conv_pixel_out (>= 1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin frame; honoured only in IDLE
- in_pixel  in  WORD_SIZE  upstream pixel
- in_valid  in  1  upstream pixel valid
- in_ready  out  1  high in STREAM only
- conv_pixel_in  out  WORD_SIZE  to datapath; in_pixel when accepted, else 0
- conv_pixel_out  in  WORD_SIZE  datapath result
- out_pixel  out  WORD_SIZE  conv_pixel_out passed through combinationally
- out_valid  out  1  out_pixel is an interior-window result
- out_last  out  1  with out_valid on the final interior result of the frame
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at frame end (clean or aborted)
- err  out  1  sticky underrun flag; cleared by reset or by the next accepted start
- frame_cnt  out  16  completed clean frames (see Configuration)

## Operation
- States: IDLE, STREAM, FLUSH, DONE.
- IDLE: in_ready=0, conv_pixel_in=0. start=1 -> STREAM, col/row counters cleared, err cleared.
- STREAM: in_ready=1. Each cycle with in_valid=1 the pixel is accepted: conv_pixel_in=in_pixel, col increments, wraps ROW_SIZE-1 -> 0 and increments row.
- Tag for the accepted pixel = (row>=2 && col>=2). Last = (row==NUM_ROWS-1 && col==ROW_SIZE-1).
- Accepting the last pixel -> FLUSH.
- Underrun: in_valid=0 while in STREAM. That cycle conv_pixel_in=0, err<=1, the whole tag pipeline is cleared so no out_valid occurs for this frame, and the state goes to FLUSH.
- FLUSH: in_ready=0, conv_pixel_in=0, drain counter runs PIPE_LAT cycles, then DONE.
- DONE: done=1 for one cycle, then IDLE. start in DONE is ignored.
- Tag pipeline: PIPE_LAT-stage shift register of {tag, last}, shifted every cycle, zeros inserted when no pixel is accepted. out_valid/out_last = final stage.
- Output has no backpressure; the consumer must take every out_valid beat.
- Clean frame yields exactly (NUM_ROWS-2)*(ROW_SIZE-2) out_valid beats.

## Timing
- Reset (async assert): state=IDLE, counters=0, tag pipeline=0, in_ready=0, conv_pixel_in=0, out_valid=0, out_last=0, busy=0, done=0, err=0, frame_cnt=0. Release is synchronous to clk.
- start sampled at edge E -> STREAM from E+1. First acceptance possible at cycle E+1.
- A pixel accepted at cycle t with tag=1 gives out_valid at t+PIPE_LAT.
- Last pixel accepted at cycle T: FLUSH spans T+1..T+PIPE_LAT. out_valid&&out_last at T+PIPE_LAT. done at T+PIPE_LAT+1. IDLE at T+PIPE_LAT+2, where a new start is accepted.
- Underrun at cycle U: out_valid=0 from U+1 onward. done at U+PIPE_LAT+1.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values, and no done pulse.

## Configuration
- CONV_CTRL_STATS_EN defined: frame_cnt increments (wrapping at 16 bits) in the DONE cycle of each frame with err=0.
- Not defined: frame_cnt tied to 0 and no counter logic is synthesised.

## Test plan
(ROW_SIZE=10, NUM_ROWS=10, PIPE_LAT=4)
- start at cycle 0, 100 back-to-back valid pixels from cycle 1 -> first out_valid at cycle 27, 64 out_valid beats total, out_last at cycle 104, done at cycle 105, err=0.
- in_valid low at the 50th STREAM cycle -> err=1, no out_valid afterwards, done 5 cycles later, frame_cnt unchanged with STATS_EN.
- start held high continuously across two frames -> second frame begins only after return to IDLE; done pulses once per frame; frame_cnt=2 with STATS_EN.
- rst_n asserted mid-FLUSH -> all outputs 0 immediately, no done pulse; a following start runs a clean frame.
- start while busy, and in_valid toggling in IDLE -> ignored; in_ready stays 0 and conv_pixel_in stays 0.
- Output ramp: in_pixel = index mod 256 -> out_valid positions match interior windows only; out_pixel equals the reference model of the datapath output.
